// File: rtl/cache_lru_state.sv
// Per-set 4x4 matrix LRU store with victim-way selection and a sequential flush walk.
// Touch/alloc writes land at the accepting edge; victim_way is registered with one cycle of latency; req_ready drops while flushing.
module cache_lru_state #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   req_ready,
  input  logic                   touch_valid,
  input  logic [INDEX_WIDTH-1:0] touch_index,
  input  logic [1:0]             touch_way,
  input  logic                   victim_req,
  input  logic [INDEX_WIDTH-1:0] victim_index,
  input  logic                   victim_alloc,
  output logic                   victim_valid,
  output logic [1:0]             victim_way
);

  localparam int NSETS = 1 << INDEX_WIDTH;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                   victim_valid_q, victim_valid_d;
  logic [1:0]             victim_way_q, victim_way_d;

  logic [15:0] lru_mem [NSETS];

  logic        touch_acc, victim_acc, same_idx;
  logic        touch_wr, alloc_wr;
  logic [15:0] touch_new, victim_mat, alloc_new;
  logic [1:0]  victim_sel;

  function automatic logic [15:0] lru_touch(input logic [15:0] m, input logic [1:0] w);
    logic [15:0] r;
    logic [3:0]  onehot;
    onehot = 4'b0001 << w;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = m[4*i +: 4] & ~onehot;
    end
    r[{w, 2'b00} +: 4] = ~onehot;
    return r;
  endfunction

  function automatic logic [1:0] row_cnt(input logic [3:0] row);
    logic [2:0] s;
    s = {2'b00, row[0]} + {2'b00, row[1]} + {2'b00, row[2]} + {2'b00, row[3]};
    return (s > 3'd3) ? 2'd3 : s[1:0];
  endfunction

  // Scanning from way 3 down with <= leaves the lowest way on a tie.
  function automatic logic [1:0] lru_victim(input logic [15:0] m);
    logic [1:0] best;
    logic [1:0] best_cnt;
    logic [1:0] cnt;
    best     = 2'd0;
    best_cnt = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      cnt = row_cnt(m[4*i +: 4]);
      if (cnt <= best_cnt) begin
        best     = i[1:0];
        best_cnt = cnt;
      end
    end
    return best;
  endfunction

  assign flush_busy   = (state_q == ST_FLUSH);
  assign req_ready    = (state_q == ST_IDLE);
  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;

  // A same-set victim sees the post-touch matrix; alloc then folds into a single write.
  always_comb begin
    touch_acc  = req_ready & touch_valid;
    victim_acc = req_ready & victim_req;
    same_idx   = touch_acc & (touch_index == victim_index);
    touch_new  = lru_touch(lru_mem[touch_index], touch_way);
    victim_mat = same_idx ? touch_new : lru_mem[victim_index];
    victim_sel = lru_victim(victim_mat);
    alloc_new  = lru_touch(victim_mat, victim_sel);
    alloc_wr   = victim_acc & victim_alloc;
    touch_wr   = touch_acc & ~(alloc_wr & same_idx);
  end

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    victim_valid_d = 1'b0;
    victim_way_d   = victim_way_q;
    case (state_q)
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == {INDEX_WIDTH{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (victim_acc) begin
          victim_valid_d = 1'b1;
          victim_way_d   = victim_sel;
        end
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_FLUSH;
      flush_cnt_q    <= '0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= 2'd0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_FLUSH) begin
      lru_mem[flush_cnt_q] <= 16'h0000;
    end
    if (touch_wr) begin
      lru_mem[touch_index] <= touch_new;
    end
    if (alloc_wr) begin
      lru_mem[victim_index] <= alloc_new;
    end
  end

endmodule

// File: tb/tb_cache_lru_state.sv
// Bench for cache_lru_state: directed vector table, multi-cycle flush/reset sequences,
// and random traffic against a recency-timestamp model of LRU behaviour.
module tb_cache_lru_state;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush_req = 1'b0;
  logic       flush_busy, req_ready;
  logic       touch_valid = 1'b0;
  logic [5:0] touch_index = '0;
  logic [1:0] touch_way = '0;
  logic       victim_req = 1'b0;
  logic [5:0] victim_index = '0;
  logic       victim_alloc = 1'b0;
  logic       victim_valid;
  logic [1:0] victim_way;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_lru_state #(.INDEX_WIDTH(6)) dut (
    .clk(clk), .rstn(rstn), .flush_req(flush_req), .flush_busy(flush_busy),
    .req_ready(req_ready), .touch_valid(touch_valid), .touch_index(touch_index),
    .touch_way(touch_way), .victim_req(victim_req), .victim_index(victim_index),
    .victim_alloc(victim_alloc), .victim_valid(victim_valid), .victim_way(victim_way)
  );

  // Model: each way of each set carries the time of its last use (0 = never used since
  // the set was cleared). A way's row popcount is the number of ways it is newer than.
  int unsigned st [64][4];
  int unsigned now_t = 0;
  logic        mbusy = 1'b1;
  int          mcnt = 0;
  logic        mvalid = 1'b0;
  logic [1:0]  mway = 2'd0;

  function automatic logic [1:0] model_victim(input int s);
    int best, best_cnt, c;
    best = 0;
    best_cnt = 99;
    for (int w = 0; w < 4; w++) begin
      c = 0;
      for (int j = 0; j < 4; j++) if (j != w && st[s][w] > st[s][j]) c++;
      if (c < best_cnt) begin
        best = w;
        best_cnt = c;
      end
    end
    return best[1:0];
  endfunction

  task automatic model_reset();
    mbusy = 1'b1; mcnt = 0; mvalid = 1'b0; mway = 2'd0;
  endtask

  task automatic model_step();
    logic [1:0] w;
    if (!rstn) begin
      model_reset();
    end else if (mbusy) begin
      for (int k = 0; k < 4; k++) st[mcnt][k] = 0;
      mvalid = 1'b0;
      if (mcnt == 63) mbusy = 1'b0;
      mcnt++;
    end else begin
      if (touch_valid) begin
        now_t++;
        st[touch_index][touch_way] = now_t;
      end
      mvalid = victim_req;
      if (victim_req) begin
        w = model_victim(int'(victim_index));
        mway = w;
        if (victim_alloc) begin
          now_t++;
          st[victim_index][w] = now_t;
        end
      end
      if (flush_req) begin
        mbusy = 1'b1;
        mcnt = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    chk("flush_busy", {31'd0, flush_busy}, {31'd0, mbusy});
    chk("req_ready", {31'd0, req_ready}, {31'd0, ~mbusy});
    chk("victim_valid", {31'd0, victim_valid}, {31'd0, mvalid});
    chk("victim_way", {30'd0, victim_way}, {30'd0, mway});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic idle_inputs();
    flush_req = 1'b0; touch_valid = 1'b0; victim_req = 1'b0; victim_alloc = 1'b0;
  endtask

  task automatic measure_flush(input string name);
    int n, guard;
    n = flush_busy ? 1 : 0;
    guard = 0;
    while (flush_busy === 1'b1 && guard < 200) begin
      tick();
      guard++;
      if (flush_busy === 1'b1) n++;
    end
    chk(name, n, 64);
  endtask

  typedef struct {
    logic       tv;
    logic [5:0] ti;
    logic [1:0] tw;
    logic       vr;
    logic [5:0] vi;
    logic       va;
    logic       ev;
    logic [1:0] ew;
  } vec_t;

  function automatic vec_t mk(input logic tv, input int ti, input int tw, input logic vr,
                              input int vi, input logic va, input logic ev, input int ew);
    vec_t v;
    v.tv = tv; v.ti = ti[5:0]; v.tw = tw[1:0];
    v.vr = vr; v.vi = vi[5:0]; v.va = va;
    v.ev = ev; v.ew = ew[1:0];
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    int guard, bad;

    vecs.push_back(mk(0, 0, 0, 1, 5, 0, 1, 0));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 1, 0));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 7, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 7, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 7, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1, 7, 1, 1, 3));
    vecs.push_back(mk(0, 0, 0, 1, 7, 1, 1, 0));
    vecs.push_back(mk(1, 9, 0, 1, 9, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 9, 0, 1, 1));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0));

    // Power-on reset and first flush walk.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_outputs();
    rstn = 1'b1;
    measure_flush("flush_len_por");

    // Directed vectors, one cycle each.
    foreach (vecs[i]) begin
      touch_valid = vecs[i].tv; touch_index = vecs[i].ti; touch_way = vecs[i].tw;
      victim_req = vecs[i].vr; victim_index = vecs[i].vi; victim_alloc = vecs[i].va;
      tick();
      chk($sformatf("tbl%0d_valid", i), {31'd0, victim_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) chk($sformatf("tbl%0d_way", i), {30'd0, victim_way}, {30'd0, vecs[i].ew});
    end
    idle_inputs();

    // Flush with a victim request held throughout the busy period.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    victim_req = 1'b1; victim_index = 6'd2; victim_alloc = 1'b0;
    guard = 0; bad = 0;
    while (victim_valid !== 1'b1 && guard < 200) begin
      tick();
      guard++;
      if (victim_valid === 1'b1 && flush_busy === 1'b1) bad++;
    end
    chk("valid_while_busy", bad, 0);
    chk("flush_wait", guard, 65);
    chk("post_flush_way", {30'd0, victim_way}, 32'd0);
    idle_inputs();
    tick();

    // Random traffic over a few sets so touches and victims collide often.
    for (int c = 0; c < 1500; c++) begin
      touch_valid  = $urandom_range(0, 1);
      touch_index  = 6'($urandom_range(0, 7));
      touch_way    = 2'($urandom_range(0, 3));
      victim_req   = $urandom_range(0, 1);
      victim_index = ($urandom_range(0, 3) == 0) ? touch_index : 6'($urandom_range(0, 7));
      victim_alloc = $urandom_range(0, 1);
      flush_req    = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle_inputs();

    guard = 0;
    while (flush_busy === 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    chk("idle_before_reset", {31'd0, req_ready}, 32'd1);

    // Asynchronous reset right after an accepted victim request drops the pulse.
    victim_req = 1'b1; victim_index = 6'd3; victim_alloc = 1'b0;
    tick();
    victim_req = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    model_reset();
    chk_outputs();
    repeat (3) tick();
    rstn = 1'b1;
    repeat (20) tick();

    // Reset at flush count 20, held three cycles, then a full walk again.
    rstn = 1'b0;
    #1;
    model_reset();
    chk_outputs();
    repeat (3) tick();
    rstn = 1'b1;
    measure_flush("flush_len_rst");
    victim_req = 1'b1; victim_index = 6'd7; victim_alloc = 1'b0;
    tick();
    chk("after_rst_way", {30'd0, victim_way}, 32'd0);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
